// File: rtl/param_nand_processor.sv
// param_nand_processor
//   Tiny single-instruction (NAND + conditional relative branch) processor with a
//   loadable instruction memory.
//
//   Instruction word (LSB first): [0] CTRL, then three ADDR_W-bit fields A, B, C.
//     CTRL=1 : reg[C] <= ~(reg[A] & reg[B]), pc <= pc + 1
//     CTRL=0 : J = {C,B}; J[MSB] selects backward, the rest is magnitude M.
//              reg[A]==0 -> pc + 1; reg[A]==1 and M!=0 -> pc +/- M; M==0 -> halt.
//
//   Register address map: 0 = constant 1, then in_reg, out_reg, internal regs;
//   anything past the internal regs reads as 0 and ignores writes.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   load_en    : request load mode
//   load_valid : load_data carries an instruction word
//   load_data  : instruction word to store
//   load_ready : high while in load mode (word accepted when load_valid)
//   run        : start/resume execution
//   in_reg     : input register bits
//   out_reg    : output register bits
//   pc         : current program counter
//   halted     : processor is in the halt state

module param_nand_processor #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned N_OUT  = 7,
    parameter int unsigned N_INT  = 6,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned PC_W   = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_en,
    input  logic                load_valid,
    input  logic [3*ADDR_W:0]   load_data,
    output logic                load_ready,
    input  logic                run,
    input  logic [N_IN-1:0]     in_reg,
    output logic [N_OUT-1:0]    out_reg,
    output logic [PC_W-1:0]     pc,
    output logic                halted
);

    localparam int unsigned InstrW  = 1 + 3 * ADDR_W;
    localparam int unsigned Depth   = 2 ** PC_W;
    localparam int unsigned NAddr   = 2 ** ADDR_W;
    localparam int unsigned OutBase = 1 + N_IN;
    localparam int unsigned IntBase = OutBase + N_OUT;
    localparam int unsigned JmpW    = 2 * ADDR_W;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StHalt
    } state_e;

    state_e state_q;
    logic   load_ready_q;
    logic   halted_q;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   load_ptr_q, load_ptr_d;
    logic [N_OUT-1:0]  out_q, out_d;
    logic [N_INT-1:0]  int_q, int_d;

    logic [InstrW-1:0] imem_q [Depth];

    // Instruction decode
    logic [InstrW-1:0] instr;
    logic              ctrl;
    logic [ADDR_W-1:0] addr_a, addr_b, addr_c;
    logic [JmpW-1:0]   jmp;
    logic              jmp_back;
    logic [JmpW-2:0]   jmp_mag;
    logic [PC_W-1:0]   jmp_mag_pc;

    logic [NAddr-1:0]  rd_vec;
    logic              rd_a, rd_b, nand_res;
    logic              exec, halt_req, imem_we;

    assign instr      = imem_q[pc_q];
    assign ctrl       = instr[0];
    assign addr_a     = instr[ADDR_W:1];
    assign addr_b     = instr[2*ADDR_W:ADDR_W+1];
    assign addr_c     = instr[3*ADDR_W:2*ADDR_W+1];
    assign jmp        = {addr_c, addr_b};
    assign jmp_back   = jmp[JmpW-1];
    assign jmp_mag    = jmp[JmpW-2:0];
    // Offset is applied modulo 2**PC_W, so truncating a wider magnitude is exact.
    assign jmp_mag_pc = PC_W'(jmp_mag);

    // Flattened read view of the whole address space; unmapped addresses read 0
    // through the zero extension of the cast.
    assign rd_vec   = NAddr'({int_q, out_q, in_reg, 1'b1});
    assign rd_a     = rd_vec[addr_a];
    assign rd_b     = rd_vec[addr_b];
    assign nand_res = ~(rd_a & rd_b);

    assign exec     = (state_q == StRun);
    assign halt_req = exec && !ctrl && rd_a && (jmp_mag == '0);
    assign imem_we  = load_ready_q && load_valid;

    // Register write-back: only output and internal registers are writable.
    always_comb begin
        out_d = out_q;
        int_d = int_q;
        if (exec && ctrl) begin
            for (int unsigned i = 0; i < N_OUT; i++) begin
                if (32'(addr_c) == OutBase + i) out_d[i] = nand_res;
            end
            for (int unsigned i = 0; i < N_INT; i++) begin
                if (32'(addr_c) == IntBase + i) int_d[i] = nand_res;
            end
        end
    end

    // Program counter
    always_comb begin
        pc_d = pc_q;
        if (exec) begin
            if (ctrl || !rd_a) begin
                pc_d = pc_q + PC_W'(1);
            end else if (jmp_mag != '0) begin
                pc_d = jmp_back ? (pc_q - jmp_mag_pc) : (pc_q + jmp_mag_pc);
            end
        end
    end

    // Load pointer restarts only on a fresh entry from idle.
    always_comb begin
        load_ptr_d = load_ptr_q;
        if (state_q == StIdle && load_en) begin
            load_ptr_d = '0;
        end else if (imem_we) begin
            load_ptr_d = load_ptr_q + PC_W'(1);
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            load_ready_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (load_en) begin
                        state_q      <= StLoad;
                        load_ready_q <= 1'b1;
                    end else if (run) begin
                        state_q      <= StRun;
                    end
                end
                StLoad: begin
                    if (!load_en) begin
                        state_q      <= StIdle;
                        load_ready_q <= 1'b0;
                    end
                end
                StRun: begin
                    if (halt_req) begin
                        state_q      <= StHalt;
                        halted_q     <= 1'b1;
                    end
                end
                StHalt: begin
                    if (load_en) begin
                        state_q      <= StLoad;
                        load_ready_q <= 1'b1;
                        halted_q     <= 1'b0;
                    end else if (run) begin
                        state_q      <= StRun;
                        halted_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    load_ready_q <= 1'b0;
                    halted_q     <= 1'b0;
                end
            endcase
        end
    end

    // Architectural state
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= '0;
            load_ptr_q <= '0;
            out_q      <= '0;
            int_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            load_ptr_q <= load_ptr_d;
            out_q      <= out_d;
            int_q      <= int_d;
        end
    end

    // Instruction memory is deliberately outside reset so programs survive it.
    always_ff @(posedge clk) begin
        if (imem_we) imem_q[load_ptr_q] <= load_data;
    end

    assign load_ready = load_ready_q;
    assign halted     = halted_q;
    assign out_reg    = out_q;
    assign pc         = pc_q;

endmodule
